// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-strobe helper
// used by the memory slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } state_t;

    localparam logic OKAY  = 1'b0;
    localparam logic ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } slv_state_t;

    // Widest supported bus is 1024 bits, i.e. 128 byte lanes.
    localparam int MAX_BYTES = 128;
    localparam int OFFSET_W  = 7;

    // Lanes [offset, offset + 2^size) are enabled; callers slice to their width.
    function automatic logic [MAX_BYTES-1:0] size_to_strobe(
        input logic [2:0]          size,
        input logic [OFFSET_W-1:0] offset
    );
        logic [MAX_BYTES-1:0] mask;
        int lo;
        int hi;
        lo = int'(offset);
        hi = lo + (1 << size);
        for (int i = 0; i < MAX_BYTES; i++) begin
            mask[i] = (i >= lo) && (i < hi);
        end
        return mask;
    endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word-organised storage with byte-enabled synchronous write and
// asynchronous read. Contents are not reset.
module ahb_mem_array #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 256,
    parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [IDX_W-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: an address phase is taken when HSEL, HREADY and an
// active HTRANS coincide; its data phase ends at the first edge with HREADYOUT=1.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int AHB_DATA_WIDTH    = 64,
    parameter int AHB_ADDRESS_WIDTH = 32,
    parameter int MEM_DEPTH         = 256,
    parameter int WAIT_STATES       = 0
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic                         HSEL,
    input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    input  logic [2:0]                   HSIZE,
    input  logic [2:0]                   HBURST,
    input  logic [AHB_DATA_WIDTH-1:0]    HWDATA,
    input  logic                         HREADY,
    output logic                         HREADYOUT,
    output logic                         HRESP,
    output logic [AHB_DATA_WIDTH-1:0]    HRDATA,
    output slv_state_t                   dbg_state
);

    localparam int BYTES = AHB_DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_t                       trans;
    logic                         accept;
    logic                         err_oob;
    logic                         err_align;
    logic                         err_size;
    logic                         err;
    logic [AHB_ADDRESS_WIDTH-1:0] word_idx;
    logic [OFFSET_W-1:0]          low_addr;
    logic [OFFSET_W-1:0]          size_mask;

    slv_state_t          state;
    logic [3:0]          wait_cnt;
    logic [IDX_W-1:0]    idx_q;
    logic [OFF_W-1:0]    off_q;
    logic                write_q;
    logic [2:0]          size_q;
    logic                ready_q;
    logic                resp_q;

    logic                      mem_we;
    logic [MAX_BYTES-1:0]      strobe_full;
    logic [AHB_DATA_WIDTH-1:0] mem_rdata;
    logic                      unused_bits;

    assign trans    = state_t'(HTRANS);
    assign accept   = HSEL && HREADY && (trans == NONSEQ || trans == SEQ);

    // Address-phase decode; any of the three faults turns the beat into ERROR.
    assign word_idx  = HADDR >> OFF_W;
    assign err_oob   = word_idx >= AHB_ADDRESS_WIDTH'(MEM_DEPTH);
    assign low_addr  = HADDR[OFFSET_W-1:0];
    assign size_mask = OFFSET_W'((8'd1 << HSIZE) - 8'd1);
    assign err_align = (low_addr & size_mask) != '0;
    assign err_size  = HSIZE > 3'(OFF_W);
    assign err       = err_oob | err_align | err_size;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            idx_q    <= '0;
            off_q    <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            ready_q  <= 1'b1;
            resp_q   <= OKAY;
        end else begin
            case (state)
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state   <= S_DATA;
                        ready_q <= 1'b1;
                    end
                end
                S_ERR1: begin
                    state   <= S_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= ERROR;
                end
                // S_IDLE, S_DATA and S_ERR2 all sample a new address phase.
                default: begin
                    if (accept) begin
                        idx_q   <= HADDR[OFF_W +: IDX_W];
                        off_q   <= HADDR[OFF_W-1:0];
                        write_q <= HWRITE;
                        size_q  <= HSIZE;
                        if (err) begin
                            state   <= S_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state    <= S_WAIT;
                            wait_cnt <= 4'(WAIT_STATES);
                            ready_q  <= 1'b0;
                            resp_q   <= OKAY;
                        end else begin
                            state   <= S_DATA;
                            ready_q <= 1'b1;
                            resp_q  <= OKAY;
                        end
                    end else begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= OKAY;
                    end
                end
            endcase
        end
    end

    // Writes commit on the closing edge of the OKAY data phase only.
    assign mem_we      = (state == S_DATA) && write_q;
    assign strobe_full = size_to_strobe(size_q, OFFSET_W'(off_q));

    ahb_mem_array #(
        .DATA_WIDTH (AHB_DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk   (HCLK),
        .we    (mem_we),
        .waddr (idx_q),
        .wstrb (strobe_full[BYTES-1:0]),
        .wdata (HWDATA),
        .raddr (idx_q),
        .rdata (mem_rdata)
    );

    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;
    assign HRDATA    = (state == S_DATA) ? mem_rdata : '0;
    assign dbg_state = state;

    assign unused_bits = ^{HBURST, strobe_full};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: three instances with 0, 3 and 4 wait
// states share one bus; sel picks which one is addressed and observed.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [63:0] hwdata;
    logic        hready_block;
    logic [1:0]  sel;

    logic [2:0]  hreadyout_v;
    logic [2:0]  hresp_v;
    logic [63:0] hrdata_v [3];
    slv_state_t  st_v [3];

    logic        cur_rdy;
    logic        cur_resp;
    logic [63:0] cur_rdata;
    slv_state_t  cur_state;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q [$];

    // Clock / reset
    always #5 hclk = ~hclk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_slave_mem #(
            .AHB_DATA_WIDTH    (64),
            .AHB_ADDRESS_WIDTH (32),
            .MEM_DEPTH         (256),
            .WAIT_STATES       ((g == 0) ? 0 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .HCLK      (hclk),
            .HRESETn   (hresetn),
            .HSEL      (hsel && (sel == 2'(g))),
            .HADDR     (haddr),
            .HTRANS    (htrans),
            .HWRITE    (hwrite),
            .HSIZE     (hsize),
            .HBURST    (hburst),
            .HWDATA    (hwdata),
            .HREADY    (hreadyout_v[g] & ~hready_block),
            .HREADYOUT (hreadyout_v[g]),
            .HRESP     (hresp_v[g]),
            .HRDATA    (hrdata_v[g]),
            .dbg_state (st_v[g])
        );
    end

    assign cur_rdy   = hreadyout_v[sel];
    assign cur_resp  = hresp_v[sel];
    assign cur_rdata = hrdata_v[sel];
    assign cur_state = st_v[sel];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Driver: called at a negedge right after the address edge; waits for HREADYOUT.
    task automatic data_phase(output int stalls, output logic [63:0] rd,
                              output logic r_first, output logic r_last);
        int n;
        n = 0;
        stalls = 0;
        r_first = cur_resp;
        while (!cur_rdy && n < 40) begin
            stalls++;
            n++;
            @(negedge hclk);
        end
        check("ready_bound", {63'd0, cur_rdy}, 64'd1);
        rd = cur_rdata;
        r_last = cur_resp;
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [63:0] wd, output int stalls, output logic [63:0] rd,
                        output logic r_first, output logic r_last);
        @(negedge hclk);
        hsel   = 1'b1;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        htrans = NONSEQ;
        @(negedge hclk);
        htrans = IDLE;
        hwdata = wd;
        data_phase(stalls, rd, r_first, r_last);
    endtask

    task automatic xfer_check(input string tag, input logic wr, input logic [31:0] addr,
                              input logic [2:0] size, input logic [63:0] wd, input int exp_stalls,
                              input logic exp_err, input logic [63:0] exp_rd);
        int st;
        logic [63:0] rd;
        logic rf;
        logic rl;
        xfer(wr, addr, size, wd, st, rd, rf, rl);
        check({tag, "_stalls"}, 64'(st), 64'(exp_stalls));
        check({tag, "_resp1"}, {63'd0, rf}, {63'd0, exp_err});
        check({tag, "_resp2"}, {63'd0, rl}, {63'd0, exp_err});
        if (!wr || exp_err) check({tag, "_rdata"}, rd, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st;
        logic [63:0] rd;
        logic rf;
        logic rl;

        hresetn = 1'b0;
        hsel = 1'b0;
        haddr = '0;
        htrans = IDLE;
        hwrite = 1'b0;
        hsize = 3'd3;
        hburst = 3'd0;
        hwdata = '0;
        hready_block = 1'b0;
        sel = 2'd0;

        repeat (3) @(negedge hclk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_ready%0d", k), {63'd0, hreadyout_v[k]}, 64'd1);
            check($sformatf("rst_resp%0d", k), {63'd0, hresp_v[k]}, 64'd0);
            check($sformatf("rst_rdata%0d", k), hrdata_v[k], 64'd0);
            check($sformatf("rst_state%0d", k), 64'(st_v[k]), 64'(S_IDLE));
        end
        hresetn = 1'b1;

        // Zero-wait write then read
        sel = 2'd0;
        xfer_check("ws0_wr", 1'b1, 32'h10, 3'd3, 64'hDEADBEEF_CAFEF00D, 0, 1'b0, 64'd0);
        xfer_check("ws0_rd", 1'b0, 32'h10, 3'd3, 64'd0, 0, 1'b0, 64'hDEADBEEF_CAFEF00D);

        // Write immediately followed by a read of the same word
        @(negedge hclk);
        hsel = 1'b1; haddr = 32'h18; hwrite = 1'b1; hsize = 3'd3; htrans = NONSEQ;
        @(negedge hclk);
        check("b2b_wr_ready", {63'd0, cur_rdy}, 64'd1);
        hwrite = 1'b0;
        hwdata = 64'h5555_AAAA_1234_5678;
        @(negedge hclk);
        htrans = IDLE;
        data_phase(st, rd, rf, rl);
        check("b2b_rd_stalls", 64'(st), 64'd0);
        check("b2b_rd_rdata", rd, 64'h5555_AAAA_1234_5678);

        // Sub-word writes
        xfer_check("byte_clr", 1'b1, 32'h10, 3'd3, 64'd0, 0, 1'b0, 64'd0);
        xfer_check("byte_wr", 1'b1, 32'h13, 3'd0, 64'h00000000_AA000000, 0, 1'b0, 64'd0);
        xfer_check("byte_rd", 1'b0, 32'h10, 3'd3, 64'd0, 0, 1'b0, 64'h00000000_AA000000);
        xfer_check("half_wr", 1'b1, 32'h16, 3'd1, 64'h1234_0000_0000_0000, 0, 1'b0, 64'd0);
        xfer_check("half_rd", 1'b0, 32'h10, 3'd3, 64'd0, 0, 1'b0, 64'h1234_0000_AA00_0000);

        // Error responses; 0x808 would alias word 1 if the range check were missing
        xfer_check("pre_08", 1'b1, 32'h08, 3'd3, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 64'd0);
        xfer_check("err_oob", 1'b1, 32'h808, 3'd3, '1, 1, 1'b1, 64'd0);
        xfer_check("err_align_rd", 1'b0, 32'h02, 3'd2, 64'd0, 1, 1'b1, 64'd0);
        xfer_check("err_align_wr", 1'b1, 32'h11, 3'd1, '1, 1, 1'b1, 64'd0);
        xfer_check("err_size", 1'b0, 32'h00, 3'd4, 64'd0, 1, 1'b1, 64'd0);
        xfer_check("err_chk08", 1'b0, 32'h08, 3'd3, 64'd0, 0, 1'b0, 64'h0123_4567_89AB_CDEF);
        xfer_check("err_chk10", 1'b0, 32'h10, 3'd3, 64'd0, 0, 1'b0, 64'h1234_0000_AA00_0000);
        xfer_check("last_wr", 1'b1, 32'h7F8, 3'd3, 64'hFEED_FACE_0BAD_F00D, 0, 1'b0, 64'd0);
        xfer_check("last_rd", 1'b0, 32'h7F8, 3'd3, 64'd0, 0, 1'b0, 64'hFEED_FACE_0BAD_F00D);

        // No-access cycles: IDLE, BUSY, HSEL=0, HREADY=0
        hwdata = '1;
        for (int k = 0; k < 4; k++) begin
            @(negedge hclk);
            hsel = 1'b1; hready_block = 1'b0; htrans = NONSEQ;
            haddr = 32'h10; hwrite = 1'b1; hsize = 3'd3;
            case (k)
                0: htrans = IDLE;
                1: htrans = BUSY;
                2: hsel = 1'b0;
                default: hready_block = 1'b1;
            endcase
            @(negedge hclk);
            hsel = 1'b1; hready_block = 1'b0; htrans = IDLE;
            check($sformatf("noacc%0d_ready", k), {63'd0, cur_rdy}, 64'd1);
            check($sformatf("noacc%0d_resp", k), {63'd0, cur_resp}, 64'd0);
            check($sformatf("noacc%0d_rdata", k), cur_rdata, 64'd0);
            check($sformatf("noacc%0d_state", k), 64'(cur_state), 64'(S_IDLE));
        end
        xfer_check("noacc_rd", 1'b0, 32'h10, 3'd3, 64'd0, 0, 1'b0, 64'h1234_0000_AA00_0000);

        // Three wait states
        sel = 2'd1;
        xfer_check("ws3_wr40", 1'b1, 32'h40, 3'd3, 64'h1111_2222_3333_4444, 3, 1'b0, 64'd0);
        xfer_check("ws3_wr48", 1'b1, 32'h48, 3'd3, 64'h5555_6666_7777_8888, 3, 1'b0, 64'd0);
        xfer_check("ws3_rd40", 1'b0, 32'h40, 3'd3, 64'd0, 3, 1'b0, 64'h1111_2222_3333_4444);

        // Back-to-back NONSEQ reads, second address held during the first stall
        exp_q.push_back(64'h5555_6666_7777_8888);
        exp_q.push_back(64'h1111_2222_3333_4444);
        @(negedge hclk);
        hsel = 1'b1; haddr = 32'h48; hwrite = 1'b0; hsize = 3'd3; htrans = NONSEQ;
        @(negedge hclk);
        haddr = 32'h40;
        data_phase(st, rd, rf, rl);
        check("ws3_b2b_a_stalls", 64'(st), 64'd3);
        check("ws3_b2b_a_rdata", rd, exp_q.pop_front());
        @(negedge hclk);
        htrans = IDLE;
        data_phase(st, rd, rf, rl);
        check("ws3_b2b_b_stalls", 64'(st), 64'd3);
        check("ws3_b2b_b_rdata", rd, exp_q.pop_front());

        // Reset in the second wait cycle of a write
        sel = 2'd2;
        xfer_check("ws4_wr", 1'b1, 32'h20, 3'd3, 64'hA5A5_A5A5_5A5A_5A5A, 4, 1'b0, 64'd0);
        @(negedge hclk);
        hsel = 1'b1; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd3; htrans = NONSEQ;
        @(negedge hclk);
        htrans = IDLE;
        hwdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge hclk);
        check("rst_mid_pre_ready", {63'd0, cur_rdy}, 64'd0);
        check("rst_mid_pre_state", 64'(cur_state), 64'(S_WAIT));
        hresetn = 1'b0;
        #1;
        check("rst_mid_ready", {63'd0, cur_rdy}, 64'd1);
        check("rst_mid_resp", {63'd0, cur_resp}, 64'd0);
        check("rst_mid_rdata", cur_rdata, 64'd0);
        check("rst_mid_state", 64'(cur_state), 64'(S_IDLE));
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        xfer_check("ws4_rd_after_rst", 1'b0, 32'h20, 3'd3, 64'd0, 4, 1'b0, 64'hA5A5_A5A5_5A5A_5A5A);

        repeat (2) @(negedge hclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-Lite memory slave that answers the transfers the AXI-to-AHB bridge issues as AHB master. It stores write data, returns read data on HRDATA, inserts a configurable number of wait states, and produces the two-cycle AHB ERROR response. It sits on the AHB side of the bridge and is used as the target in bridge system simulations.

## Interface
- AHB_DATA_WIDTH, 64: HWDATA/HRDATA width in bits; one memory word; power of two, 32..1024.
- AHB_ADDRESS_WIDTH, 32: HADDR width.
- MEM_DEPTH, 256: number of words; byte capacity = MEM_DEPTH*AHB_DATA_WIDTH/8.
- WAIT_STATES, 0: wait cycles (HREADYOUT=0) inserted in each OKAY data phase; 0..15.

- HCLK  in  1  clock; everything is on the rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  AHB_ADDRESS_WIDTH  byte address (address phase).
- HTRANS  in  2  transfer type, decoded as ahb_pkg::state_t.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  bytes = 2^HSIZE.
- HBURST  in  3  ignored; every beat is decoded on its own.
- HWDATA  in  AHB_DATA_WIDTH  write data (data phase).
- HREADY  in  1  bus-level ready; an address phase is sampled only when this is 1.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  AHB_DATA_WIDTH  read data.

## Operation
- **Address phase accept.** Accepted when HSEL && HREADY && HTRANS ∈ {NONSEQ, SEQ}. On accept, register addr, write, and size.
- **Error decode** at accept. An error occurs on any of:
  - word index = HADDR / (AHB_DATA_WIDTH/8) ≥ MEM_DEPTH;
  - HADDR not aligned to 2^HSIZE;
  - 2^HSIZE > AHB_DATA_WIDTH/8.
- **No-access cases.** IDLE, BUSY, HSEL=0, or HREADY=0 accept nothing. The next cycle is a zero-wait OKAY with no memory access.
- **FSM states:**
  - S_IDLE: HREADYOUT=1, HRESP=0, HRDATA=0.
  - S_WAIT: HREADYOUT=0, HRESP=0. A counter loads WAIT_STATES on accept and decrements each cycle.
  - S_DATA: HREADYOUT=1, HRESP=0, final cycle of an OKAY data phase.
  - S_ERR1: HREADYOUT=0, HRESP=1.
  - S_ERR2: HREADYOUT=1, HRESP=1.
- **Transitions:**
  - Accept + error → S_ERR1.
  - Accept + OKAY + WAIT_STATES>0 → S_WAIT.
  - Accept + OKAY + WAIT_STATES=0 → S_DATA.
  - S_WAIT with counter=1 → S_DATA.
  - S_ERR1 → S_ERR2.
  - S_DATA / S_ERR2 → accept logic again (a new address phase may be sampled in the same cycle), else S_IDLE.
- **Reads.** In S_DATA, HRDATA = mem[word index], the full word with all lanes driven. HRDATA=0 in every other state.
- **Writes.** Commit at the S_DATA clock edge, using byte strobes derived from HSIZE and addr low bits. Only the lanes [offset, offset+2^HSIZE) are written.
- **Error transfers** never touch memory and skip wait states.
- **Memory** is not reset; its contents are undefined until written.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state S_IDLE, counter 0.
- OKAY latency: the data phase lasts 1+WAIT_STATES cycles after the address-phase edge.
- ERROR latency: exactly 2 cycles.
- Pipelining: back-to-back transfers accept the next address phase in the S_DATA/S_ERR2 cycle, so there are no bubbles at WAIT_STATES=0.
- Write followed immediately by a read of the same address: the read returns the new data, because the write commits before the read data phase.
- HTRANS changes to IDLE during S_ERR1 are ignored, since HREADY=0 there.
- Reset asserted mid-transfer (any state): outputs return to reset values asynchronously. The pending write is discarded and the bus resumes at S_IDLE.
- HRDATA, HREADYOUT, and HRESP are decoded from registered state only, with no combinational path from bus inputs.

## Structure
- ahb_pkg (shared):
  - state_t (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - HRESP constants OKAY=1'b0, ERROR=1'b1;
  - slave FSM enum slv_state_t;
  - function size_to_strobe(size, offset) returning a byte-enable mask.
- Sub-module: ahb_mem_array holds the storage. It has a byte-enabled synchronous write, asynchronous read, and parameters for width and depth.

## Test plan
1. **Write then read, WAIT_STATES=0.**
   - Stimulus: write 0x10, HSIZE=3, data 0xDEADBEEF_CAFEF00D; then read 0x10.
   - Required: read returns 0xDEADBEEF_CAFEF00D, HREADYOUT=1 throughout, HRESP=0.
2. **Wait states, WAIT_STATES=3.**
   - Stimulus: single read.
   - Required: HREADYOUT=0 for exactly 3 cycles, then 1 with data. Back-to-back NONSEQ reads stall 3 cycles each.
3. **Byte write.**
   - Stimulus: write word 0x10 with 0; write 0xAA at 0x13 with HSIZE=0 (HWDATA lane 3 = 0xAA); read 0x10.
   - Required: read returns 0x00000000_AA000000.
4. **Errors, MEM_DEPTH=256.**
   - Stimulus: write to 0x808 (beyond 0x7FF); read 0x02 with HSIZE=2.
   - Required: each gets ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1). Memory is unchanged and HRDATA=0.
5. **No-access cycles.**
   - Stimulus: IDLE, BUSY, HSEL=0, and HREADY=0 cycles interleaved with NONSEQ.
   - Required: no access and zero-wait OKAY on the idle cycles. The following valid transfer completes normally.
6. **Reset during write.**
   - Stimulus: with WAIT_STATES=4, assert HRESETn=0 in the 2nd wait cycle of a write to 0x20, then read 0x20 after reset.
   - Required: outputs go to reset values immediately, and the read does not return the aborted write data.
